tap_loader: RTL and testbench

Parametrised, handshaked successor to the single-file cached tape loader. It walks an Oric `.TAP` image held in the tape cache BRAM, validates each header and writes program bytes to system RAM through a ready/valid write port. It reports file type, addresses and autorun state to the core, and loads every file in a multi-file image when `TAP_LOADER_MULTIFILE_EN` is set. It sits between the ioctl-filled tape cache and the Oric RAM arbiter.

---
 rtl/tap_loader_pkg.sv | 36 +++
 rtl/tap_byte_fetch.sv | 58 +++++
 rtl/tap_loader.sv | 194 +++++++++++++++++++
 tb/tb_tap_loader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tap_loader_pkg.sv
// Shared types and constants for the Oric .TAP cache loader.
package tap_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_HDR,
    ST_NAME,
    ST_DATA,
    ST_FILE_DONE,
    ST_DONE,
    ST_ERR
  } tap_state_e;

  localparam logic [7:0] TAP_SYNC_BYTE = 8'h16;
  localparam logic [7:0] TAP_MARK_BYTE = 8'h24;
  localparam int         TAP_HDR_LEN   = 9;

  // Header byte offsets counted from the first byte after the 0x24 marker.
  localparam logic [3:0] TAP_OFS_TYPE    = 4'd2;
  localparam logic [3:0] TAP_OFS_AUTORUN = 4'd3;
  localparam logic [3:0] TAP_OFS_END_H   = 4'd4;
  localparam logic [3:0] TAP_OFS_END_L   = 4'd5;
  localparam logic [3:0] TAP_OFS_START_H = 4'd6;
  localparam logic [3:0] TAP_OFS_START_L = 4'd7;
  localparam logic [3:0] TAP_OFS_LAST    = 4'(TAP_HDR_LEN - 1);

  localparam logic [7:0] TAP_TYPE_BASIC = 8'h00;
  localparam logic [7:0] TAP_TYPE_MCODE = 8'h80;

  // Inclusive region length; 17 bits so 0x0000..0xFFFF does not wrap.
  function automatic logic [16:0] tap_data_len(input logic [15:0] sa, input logic [15:0] ea);
    return {1'b0, ea} - {1'b0, sa} + 17'd1;
  endfunction

endpackage

// File: rtl/tap_byte_fetch.sv
// Sequential tape-cache reader: each address is issued for one cycle, then held
// in the sample phase until the parser takes the byte.
module tap_byte_fetch #(
  parameter int CACHE_AW = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                restart_i,
  input  logic                en_i,
  input  logic                take_i,
  input  logic [CACHE_AW-1:0] size_i,
  output logic [CACHE_AW-1:0] cache_addr_o,
  input  logic [7:0]          cache_dout_i,
  output logic [7:0]          byte_o,
  output logic                valid_o,
  output logic                at_end_o
);

  logic [CACHE_AW-1:0] pos_q, pos_d;
  logic [CACHE_AW-1:0] size_q, size_d;
  logic                phase_q, phase_d;

  assign at_end_o     = (pos_q == size_q);
  assign cache_addr_o = pos_q;
  assign byte_o       = cache_dout_i;
  assign valid_o      = phase_q;

  always_comb begin
    pos_d   = pos_q;
    size_d  = size_q;
    phase_d = phase_q;
    if (restart_i) begin
      pos_d   = '0;
      size_d  = size_i;
      phase_d = 1'b0;
    end else if (phase_q) begin
      if (take_i) begin
        pos_d   = pos_q + CACHE_AW'(1);
        phase_d = 1'b0;
      end
    end else if (en_i && !at_end_o) begin
      phase_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pos_q   <= '0;
      size_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      size_q  <= size_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/tap_loader.sv
// Walks a .TAP image in the tape cache and writes program bytes to RAM.
// Define TAP_LOADER_MULTIFILE_EN to keep loading files after the first one.
module tap_loader
  import tap_loader_pkg::*;
#(
  parameter int CACHE_AW = 16,
  parameter int SYNC_MIN = 3,
  parameter int NAME_MAX = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [CACHE_AW-1:0] tap_size_i,
  output logic [CACHE_AW-1:0] cache_addr_o,
  input  logic [7:0]          cache_dout_i,
  output logic [15:0]         ram_addr_o,
  output logic [7:0]          ram_dout_o,
  output logic                ram_wr_o,
  input  logic                ram_ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic                autorun_o,
  output logic [7:0]          file_type_o,
  output logic [15:0]         start_addr_o,
  output logic [15:0]         end_addr_o,
  output logic [7:0]          file_count_o,
  output tap_state_e          state_o
);

  localparam logic [7:0] SYNC_MIN_L = 8'(SYNC_MIN);
  localparam logic [7:0] NAME_MAX_L = 8'(NAME_MAX);

  tap_state_e  state_q, state_d;
  logic [3:0]  hdr_idx_q, hdr_idx_d;
  logic [7:0]  sync_cnt_q, sync_cnt_d, name_cnt_q, name_cnt_d, arun_q, arun_d;
  logic [16:0] rem_q, rem_d;
  logic [15:0] ram_addr_q, ram_addr_d, start_q, start_d, end_q, end_d;
  logic [7:0]  ram_dout_q, ram_dout_d, type_q, type_d, fcnt_q, fcnt_d;
  logic        ram_wr_q, ram_wr_d, busy_q, busy_d, done_q, done_d;
  logic        error_q, error_d, autorun_q, autorun_d;
  logic        launch, take, fetch_en, accept, byte_valid, at_end;
  logic [7:0]  byte_in;

  // RAM port: a write is held stable while ram_wr_o is high and completes in
  // any cycle where ram_wr_o && ram_ready_i; a new byte may load that same cycle.
  assign accept   = ram_wr_q && ram_ready_i;
  assign fetch_en = (state_q == ST_SYNC) || (state_q == ST_HDR) || (state_q == ST_NAME) ||
                    ((state_q == ST_DATA) && (rem_q != 17'd0));

  tap_byte_fetch #(.CACHE_AW(CACHE_AW)) u_fetch (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .restart_i    (launch),
    .en_i         (fetch_en),
    .take_i       (take),
    .size_i       (tap_size_i),
    .cache_addr_o (cache_addr_o),
    .cache_dout_i (cache_dout_i),
    .byte_o       (byte_in),
    .valid_o      (byte_valid),
    .at_end_o     (at_end)
  );

  always_comb begin
    state_d = state_q;  hdr_idx_d = hdr_idx_q;  sync_cnt_d = sync_cnt_q;
    name_cnt_d = name_cnt_q;  arun_d = arun_q;  rem_d = rem_q;
    ram_addr_d = ram_addr_q;  ram_dout_d = ram_dout_q;  ram_wr_d = ram_wr_q;
    start_d = start_q;  end_d = end_q;  type_d = type_q;  fcnt_d = fcnt_q;
    done_d = done_q;  error_d = error_q;
    launch = 1'b0;
    take   = 1'b0;
    if (accept) begin
      ram_wr_d   = 1'b0;
      ram_addr_d = ram_addr_q + 16'd1;
    end
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          launch = 1'b1;  state_d = ST_SYNC;  sync_cnt_d = '0;
          done_d = 1'b0;  error_d = 1'b0;  fcnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SYNC: begin
        if (byte_valid) begin
          take = 1'b1;
          if (byte_in == TAP_SYNC_BYTE) begin
            sync_cnt_d = (sync_cnt_q < SYNC_MIN_L) ? sync_cnt_q + 8'd1 : sync_cnt_q;
          end else if (byte_in == TAP_MARK_BYTE && sync_cnt_q >= SYNC_MIN_L) begin
            state_d = ST_HDR;  hdr_idx_d = '0;  sync_cnt_d = '0;
          end else begin
            sync_cnt_d = '0;
          end
        end else if (at_end) begin
          state_d = (fcnt_q != 8'd0) ? ST_DONE : ST_ERR;
        end
      end
      ST_HDR: begin
        if (byte_valid) begin
          take      = 1'b1;
          hdr_idx_d = hdr_idx_q + 4'd1;
          case (hdr_idx_q)
            TAP_OFS_TYPE:    type_d = byte_in;
            TAP_OFS_AUTORUN: arun_d = byte_in;
            TAP_OFS_END_H:   end_d[15:8] = byte_in;
            TAP_OFS_END_L:   end_d[7:0] = byte_in;
            TAP_OFS_START_H: start_d[15:8] = byte_in;
            TAP_OFS_START_L: start_d[7:0] = byte_in;
            TAP_OFS_LAST: begin
              if (end_q < start_q) begin
                state_d = ST_ERR;
              end else begin
                state_d = ST_NAME;  name_cnt_d = '0;
                rem_d = tap_data_len(start_q, end_q);  ram_addr_d = start_q;
              end
            end
            default: ;
          endcase
        end else if (at_end) begin
          state_d = ST_ERR;
        end
      end
      ST_NAME: begin
        if (byte_valid) begin
          take = 1'b1;
          if (byte_in == 8'h00)           state_d = ST_DATA;
          else if (name_cnt_q == NAME_MAX_L) state_d = ST_ERR;
          else                            name_cnt_d = name_cnt_q + 8'd1;
        end else if (at_end) begin
          state_d = ST_ERR;
        end
      end
      ST_DATA: begin
        if (rem_q != 17'd0) begin
          if (byte_valid && (!ram_wr_q || ram_ready_i)) begin
            take = 1'b1;  rem_d = rem_q - 17'd1;
            ram_dout_d = byte_in;  ram_wr_d = 1'b1;
          end else if (at_end) begin
            state_d = ST_ERR;
          end
        end else if (!ram_wr_q || accept) begin
          state_d = ST_FILE_DONE;
        end
      end
      ST_FILE_DONE: begin
        fcnt_d = (fcnt_q != 8'hFF) ? fcnt_q + 8'd1 : fcnt_q;
`ifdef TAP_LOADER_MULTIFILE_EN
        state_d = ST_SYNC;  sync_cnt_d = '0;
`else
        state_d = ST_DONE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    // A pending write is dropped once the image is known to be bad.
    if (state_d == ST_ERR) ram_wr_d = 1'b0;
    if (state_d == ST_DONE) done_d = 1'b1;
    if (state_d == ST_ERR) error_d = 1'b1;
    busy_d    = (state_d == ST_SYNC) || (state_d == ST_HDR) || (state_d == ST_NAME) ||
                (state_d == ST_DATA) || (state_d == ST_FILE_DONE);
    autorun_d = (state_d == ST_DONE) && (state_q != ST_DONE) && (arun_q != 8'd0);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;  hdr_idx_q <= '0;  sync_cnt_q <= '0;  name_cnt_q <= '0;
      arun_q <= '0;  rem_q <= '0;  ram_addr_q <= '0;  ram_dout_q <= '0;
      ram_wr_q <= 1'b0;  start_q <= '0;  end_q <= '0;  type_q <= '0;  fcnt_q <= '0;
      busy_q <= 1'b0;  done_q <= 1'b0;  error_q <= 1'b0;  autorun_q <= 1'b0;
    end else begin
      state_q <= state_d;  hdr_idx_q <= hdr_idx_d;  sync_cnt_q <= sync_cnt_d;
      name_cnt_q <= name_cnt_d;  arun_q <= arun_d;  rem_q <= rem_d;
      ram_addr_q <= ram_addr_d;  ram_dout_q <= ram_dout_d;  ram_wr_q <= ram_wr_d;
      start_q <= start_d;  end_q <= end_d;  type_q <= type_d;  fcnt_q <= fcnt_d;
      busy_q <= busy_d;  done_q <= done_d;  error_q <= error_d;  autorun_q <= autorun_d;
    end
  end

  assign ram_addr_o   = ram_addr_q;
  assign ram_dout_o   = ram_dout_q;
  assign ram_wr_o     = ram_wr_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign autorun_o    = autorun_q;
  assign file_type_o  = type_q;
  assign start_addr_o = start_q;
  assign end_addr_o   = end_q;
  assign file_count_o = fcnt_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_tap_loader.sv
// Directed scoreboard bench for tap_loader: BASIC, autorun, backpressure,
// error images, two-file image and reset during DATA.
module tb_tap_loader;
  import tap_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] tap_size = '0;
  logic [15:0] cache_addr;
  logic [7:0]  cache_dout = '0;
  logic [15:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic        ram_ready = 1'b1;
  logic        busy, done, error, autorun;
  logic [7:0]  file_type, file_count;
  logic [15:0] start_addr, end_addr;
  tap_state_e  state;

  logic [7:0]  mem [0:65535];
  logic [23:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          wr_cnt = 0;
  int          ar_cnt = 0;
  int          wp = 0;
  bit          bp_mode = 1'b0;
  int          bp_ph = 0;

  logic        prev_pend = 1'b0, prev_done = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [7:0]  prev_dout = '0;
  logic [23:0] e;

  tap_loader dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .tap_size_i(tap_size),
    .cache_addr_o(cache_addr), .cache_dout_i(cache_dout),
    .ram_addr_o(ram_addr), .ram_dout_o(ram_dout), .ram_wr_o(ram_wr),
    .ram_ready_i(ram_ready), .busy_o(busy), .done_o(done), .error_o(error),
    .autorun_o(autorun), .file_type_o(file_type), .start_addr_o(start_addr),
    .end_addr_o(end_addr), .file_count_o(file_count), .state_o(state)
  );

  // clock / cache model / ready driver
  always #5 clk = ~clk;
  always @(posedge clk) cache_dout <= mem[cache_addr];

  initial forever begin
    @(posedge clk); #1;
    if (bp_mode) begin
      ram_ready = (bp_ph == 0) || (bp_ph == 3);
      bp_ph = (bp_ph + 1) % 4;
    end else begin
      ram_ready = 1'b1;
    end
  end

  // monitor: pops expected writes, checks hold stability and autorun timing
  always @(negedge clk) begin
    if (reset) begin
      prev_pend = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_pend) begin
        checks++;
        if (!ram_wr || ram_addr !== prev_addr || ram_dout !== prev_dout) begin
          failures++;
          $display("FAIL hold_stable: wr=%0b addr=%04h data=%02h required addr=%04h data=%02h",
                   ram_wr, ram_addr, ram_dout, prev_addr, prev_dout);
        end
      end
      if (ram_wr && ram_ready) begin
        wr_cnt++;
        checks++;
        if (error) begin
          failures++;
          $display("FAIL write_after_error: addr=%04h", ram_addr);
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: addr=%04h data=%02h", ram_addr, ram_dout);
        end else begin
          e = exp_q.pop_front();
          if ({ram_addr, ram_dout} !== e) begin
            failures++;
            $display("FAIL write_data: got %04h/%02h required %04h/%02h",
                     ram_addr, ram_dout, e[23:8], e[7:0]);
          end
        end
      end
      if (autorun) begin
        ar_cnt++;
        checks++;
        if (!(done && !prev_done)) begin
          failures++;
          $display("FAIL autorun_timing: done=%0b prev_done=%0b required 1/0", done, prev_done);
        end
      end
      prev_pend = ram_wr && !ram_ready;
      prev_addr = ram_addr;
      prev_dout = ram_dout;
      prev_done = done;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    mem[wp] = b;
    wp++;
  endtask

  // One file: sync, marker, header, name, ndata bytes; optionally expect writes.
  task automatic add_file(input logic [7:0] typ, input logic [7:0] arun,
                          input logic [15:0] sa, input logic [15:0] ea, input string nm,
                          input int ndata, input logic [7:0] seed, input bit expect_wr);
    logic [7:0] d;
    for (int i = 0; i < 4; i++) put(TAP_SYNC_BYTE);
    put(TAP_MARK_BYTE);
    put(8'hFF); put(8'hFF); put(typ); put(arun);
    put(ea[15:8]); put(ea[7:0]); put(sa[15:8]); put(sa[7:0]); put(8'h03);
    for (int i = 0; i < nm.len(); i++) put(nm[i]);
    put(8'h00);
    for (int i = 0; i < ndata; i++) begin
      d = 8'(int'(seed) + i * 7);
      put(d);
      if (expect_wr) exp_q.push_back({sa + 16'(i), d});
    end
  endtask

  task automatic clear_test();
    exp_q.delete();
    wr_cnt = 0;
    ar_cnt = 0;
    wp = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    tap_size = 16'(wp);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_load(input string name);
    bit ok;
    pulse_start();
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (done || error) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_finished"}, 32'(ok), 32'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cache_addr"}, 32'(cache_addr), 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_dout"}, 32'(ram_dout), 32'd0);
    check({tag, "_ram_wr"}, 32'(ram_wr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_autorun"}, 32'(autorun), 32'd0);
    check({tag, "_file_type"}, 32'(file_type), 32'd0);
    check({tag, "_start_addr"}, 32'(start_addr), 32'd0);
    check({tag, "_end_addr"}, 32'(end_addr), 32'd0);
    check({tag, "_file_count"}, 32'(file_count), 32'd0);
    check({tag, "_state"}, 32'(state), 32'(ST_IDLE));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_outputs("reset");

    // single BASIC file, spec image
    clear_test();
    add_file(TAP_TYPE_BASIC, 8'h00, 16'h0501, 16'h051F, "TESTSAVE", 31, 8'h11, 1'b1);
    check("basic_image_len", 32'(wp), 32'd54);
    run_load("basic");
    check("basic_done", 32'(done), 32'd1);
    check("basic_error", 32'(error), 32'd0);
    check("basic_busy", 32'(busy), 32'd0);
    check("basic_writes", 32'(wr_cnt), 32'd31);
    check("basic_q_empty", 32'(exp_q.size()), 32'd0);
    check("basic_autorun", 32'(ar_cnt), 32'd0);
    check("basic_file_count", 32'(file_count), 32'd1);
    check("basic_start_addr", 32'(start_addr), 32'h0501);
    check("basic_end_addr", 32'(end_addr), 32'h051F);

    // autorun machine code
    clear_test();
    add_file(TAP_TYPE_MCODE, 8'hC7, 16'h9800, 16'h9803, "M", 4, 8'hA0, 1'b1);
    run_load("mcode");
    check("mcode_done", 32'(done), 32'd1);
    check("mcode_writes", 32'(wr_cnt), 32'd4);
    check("mcode_autorun_pulses", 32'(ar_cnt), 32'd1);
    check("mcode_file_type", 32'(file_type), 32'h80);

    // backpressure with ready pattern 1/0/0/1
    clear_test();
    add_file(TAP_TYPE_BASIC, 8'h00, 16'h0501, 16'h051F, "TESTSAVE", 31, 8'h5A, 1'b1);
    bp_mode = 1'b1;
    run_load("bp");
    bp_mode = 1'b0;
    check("bp_done", 32'(done), 32'd1);
    check("bp_writes", 32'(wr_cnt), 32'd31);
    check("bp_q_empty", 32'(exp_q.size()), 32'd0);

    // truncated 5 bytes into DATA
    clear_test();
    add_file(TAP_TYPE_BASIC, 8'h00, 16'h0700, 16'h070F, "T", 5, 8'h01, 1'b1);
    run_load("trunc");
    check("trunc_error", 32'(error), 32'd1);
    check("trunc_done", 32'(done), 32'd0);
    check("trunc_writes_le5", 32'(wr_cnt <= 5), 32'd1);

    // end < start
    clear_test();
    add_file(TAP_TYPE_BASIC, 8'h00, 16'h0600, 16'h05FF, "X", 4, 8'h02, 1'b0);
    run_load("order");
    check("order_error", 32'(error), 32'd1);
    check("order_done", 32'(done), 32'd0);
    check("order_writes", 32'(wr_cnt), 32'd0);

    // 17-byte name
    clear_test();
    add_file(TAP_TYPE_BASIC, 8'h00, 16'h0600, 16'h0603, "ABCDEFGHIJKLMNOPQ", 4, 8'h03, 1'b0);
    run_load("name");
    check("name_error", 32'(error), 32'd1);
    check("name_done", 32'(done), 32'd0);
    check("name_writes", 32'(wr_cnt), 32'd0);

    // two files in one image; first has autorun set, second does not
    clear_test();
    add_file(TAP_TYPE_MCODE, 8'h01, 16'h0400, 16'h0403, "A", 4, 8'h30, 1'b1);
`ifdef TAP_LOADER_MULTIFILE_EN
    add_file(TAP_TYPE_BASIC, 8'h00, 16'h0500, 16'h0502, "B", 3, 8'h60, 1'b1);
`else
    add_file(TAP_TYPE_BASIC, 8'h00, 16'h0500, 16'h0502, "B", 3, 8'h60, 1'b0);
`endif
    run_load("multi");
    check("multi_done", 32'(done), 32'd1);
    check("multi_q_empty", 32'(exp_q.size()), 32'd0);
`ifdef TAP_LOADER_MULTIFILE_EN
    check("multi_file_count", 32'(file_count), 32'd2);
    check("multi_writes", 32'(wr_cnt), 32'd7);
    check("multi_autorun", 32'(ar_cnt), 32'd0);
    check("multi_start_addr", 32'(start_addr), 32'h0500);
`else
    check("multi_file_count", 32'(file_count), 32'd1);
    check("multi_writes", 32'(wr_cnt), 32'd4);
    check("multi_autorun", 32'(ar_cnt), 32'd1);
    check("multi_start_addr", 32'(start_addr), 32'h0400);
`endif

    // reset after the 10th write, then reload
    clear_test();
    add_file(TAP_TYPE_BASIC, 8'h00, 16'h0501, 16'h051F, "TESTSAVE", 31, 8'h77, 1'b1);
    pulse_start();
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      if (wr_cnt >= 10) break;
    end
    check("rst_reached_10", 32'(wr_cnt), 32'd10);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("rst_mid");
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_no_extra_writes", 32'(wr_cnt), 32'd10);
    clear_test();
    add_file(TAP_TYPE_BASIC, 8'h00, 16'h0501, 16'h051F, "TESTSAVE", 31, 8'h77, 1'b1);
    run_load("reload");
    check("reload_done", 32'(done), 32'd1);
    check("reload_writes", 32'(wr_cnt), 32'd31);
    check("reload_q_empty", 32'(exp_q.size()), 32'd0);
    check("reload_file_count", 32'(file_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
